hex_keypad_scanner: RTL and testbench



---
 rtl/hex_keypad_if.sv | 23 ++
 rtl/hex_keypad_scanner.sv | 159 +++++++++++++++
 tb/tb_hex_keypad_scanner.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hex_keypad_if.sv
// Keypad scanner signal bundle: matrix drive/sense plus the decoded key and entry register.
// The master side is the scanner itself; the slave side is the keypad plus whoever consumes the keys.
interface hex_keypad_if #(
  parameter int DW = 32
) ();
  logic [3:0]    col_o;
  logic [3:0]    row_i;
  logic          clear_i;
  logic [3:0]    key_o;
  logic          key_valid_o;
  logic          key_held_o;
  logic [DW-1:0] data_o;

  modport master (
    output col_o, key_o, key_valid_o, key_held_o, data_o,
    input  row_i, clear_i
  );

  modport slave (
    input  col_o, key_o, key_valid_o, key_held_o, data_o,
    output row_i, clear_i
  );
endinterface

// File: rtl/hex_keypad_scanner.sv
// 4x4 hex keypad scanner: one column driven low at a time, full-scan debounce,
// accepted keys shifted as hex nibbles into a DW-bit entry register.
module hex_keypad_scanner #(
  parameter int DW             = 32,
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input logic         clk,
  input logic         rst_ni,
  hex_keypad_if.master kp
);
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    case ({row, col})
      4'd0:  key_code = 4'h1;  4'd1:  key_code = 4'h2;
      4'd2:  key_code = 4'h3;  4'd3:  key_code = 4'hA;
      4'd4:  key_code = 4'h4;  4'd5:  key_code = 4'h5;
      4'd6:  key_code = 4'h6;  4'd7:  key_code = 4'hB;
      4'd8:  key_code = 4'h7;  4'd9:  key_code = 4'h8;
      4'd10: key_code = 4'h9;  4'd11: key_code = 4'hC;
      4'd12: key_code = 4'hE;  4'd13: key_code = 4'h0;
      4'd14: key_code = 4'hF;  default: key_code = 4'hD;
    endcase
  endfunction

  logic [3:0]       row_meta, row_sync;
  logic [DIV_W-1:0] div_q;
  logic [1:0]       col_idx;
  logic [3:0]       col_q;
  logic [1:0]       acc_hits;   // saturates at 2: anything above one hit is MULTI
  logic [3:0]       acc_code;
  state_t           state_q;
  logic [3:0]       cand_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       key_q;
  logic             valid_q, held_q;
  logic [DW-1:0]    data_q;

  logic             sample, scan_done, res_none, res_single, accept;
  logic [3:0]       col_lows, res_code;
  logic [2:0]       col_hits, total_hits;
  logic [1:0]       col_row;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    col_hits = '0;
    col_row  = '0;
    col_lows = ~row_sync;
    for (int r = 3; r >= 0; r--) begin
      col_hits = col_hits + 3'(col_lows[r]);
      if (col_lows[r]) col_row = 2'(r);
    end
    sample     = (div_q == DIV_W'(SCAN_DIV - 1));
    scan_done  = sample && (col_idx == 2'd3);
    total_hits = {1'b0, acc_hits} + col_hits;
    res_none   = (total_hits == 3'd0);
    res_single = (total_hits == 3'd1);
    res_code   = (acc_hits != 2'd0) ? acc_code : key_code(col_row, col_idx);
    accept     = scan_done && (state_q == DEBOUNCE) && res_single && (res_code == cand_q)
                 && (cnt_q == CNT_W'(DEBOUNCE_SCANS - 1));
  end

  // Synchronizer, column divider and per-scan hit accumulator.
  always_ff @(posedge clk or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    if (!rst_ni) begin
      row_meta <= '1;
      row_sync <= '1;
      div_q    <= '0;
      col_idx  <= '0;
      col_q    <= 4'b1110;
      acc_hits <= '0;
      acc_code <= '0;
    end else begin
      row_meta <= kp.row_i;
      row_sync <= row_meta;
      if (sample) begin
        div_q   <= '0;
        col_idx <= col_idx + 2'd1;
        col_q   <= {col_q[2:0], col_q[3]};
        if (col_idx == 2'd3) begin
          acc_hits <= '0;
          acc_code <= '0;
        end else begin
          acc_hits <= (total_hits >= 3'd2) ? 2'd2 : total_hits[1:0];
          if (acc_hits == 2'd0) acc_code <= key_code(col_row, col_idx);
        end
      end else begin
        div_q <= div_q + DIV_W'(1);
      end
    end
  end

  // Debounce FSM with registered key outputs and entry register.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cand_q  <= '0;
      cnt_q   <= '0;
      key_q   <= '0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= 1'b0;
      if (scan_done) begin
        case (state_q)
          IDLE: if (res_single) begin
            state_q <= DEBOUNCE;
            cand_q  <= res_code;
            cnt_q   <= CNT_W'(1);
          end
          DEBOUNCE: begin
            if (accept) begin
              state_q <= PRESSED;
              key_q   <= cand_q;
              valid_q <= 1'b1;
              held_q  <= 1'b1;
            end else if (res_single && res_code == cand_q) begin
              cnt_q <= cnt_q + CNT_W'(1);
            end else begin
              state_q <= IDLE;
            end
          end
          PRESSED: if (res_none) begin
            state_q <= RELEASE;
            cnt_q   <= CNT_W'(1);
          end
          RELEASE: begin
            if (!res_none) begin
              state_q <= PRESSED;
            end else if (cnt_q == CNT_W'(DEBOUNCE_SCANS - 1)) begin
              state_q <= IDLE;
              held_q  <= 1'b0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          default: state_q <= IDLE;
        endcase
      end
      if (accept) begin
        data_q <= kp.clear_i ? {{(DW-4){1'b0}}, cand_q} : {data_q[DW-5:0], cand_q};
      end else if (kp.clear_i) begin
        data_q <= '0;
      end
    end
  end

  assign kp.col_o       = col_q;
  assign kp.key_o       = key_q;
  assign kp.key_valid_o = valid_q;
  assign kp.key_held_o  = held_q;
  assign kp.data_o      = data_q;
endmodule

// File: tb/tb_hex_keypad_scanner.sv
// Scoreboard bench for hex_keypad_scanner: a keypad model drives rows from columns,
// expected accepts are queued at stimulus time and checked when key_valid_o pulses.
module tb_hex_keypad_scanner;
  localparam int DW   = 32;
  localparam int SCAN = 16;  // cycles per full scan with SCAN_DIV=4

  typedef struct {
    logic [3:0]    key;
    logic [DW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic [15:0] pressed = '0;  // bit r*4+c
  logic [3:0]  row_model;
  exp_t        exp_q[$];
  logic [DW-1:0] exp_data = '0;
  int assertions = 0;
  int failures = 0;
  int cyc = 0;
  int pulse_count = 0;
  int last_pulse_cyc = -1;
  logic prev_valid = 1'b0;

  hex_keypad_if #(.DW(DW)) kp ();

  hex_keypad_scanner #(.DW(DW), .SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
    .clk(clk), .rst_ni(rst_ni), .kp(kp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    row_model = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !kp.col_o[c]) row_model[r] = 1'b0;
  end
  assign kp.row_i = row_model;

  // Scoreboard consumer: every pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_ni && kp.key_valid_o) begin
      pulse_count++;
      last_pulse_cyc = cyc;
      assertions++;
      if (prev_valid) begin
        failures++;
        $display("FAIL valid_width: key_valid_o high two cycles in a row at cycle %0d", cyc);
      end
      if (exp_q.size() == 0) begin
        assertions++; failures++;
        $display("FAIL unexpected_pulse: key_o=%h data_o=%h, no accept expected", kp.key_o, kp.data_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        assertions++;
        if (kp.key_o !== e.key) begin
          failures++; $display("FAIL pulse_key: got %h expected %h", kp.key_o, e.key);
        end
        assertions++;
        if (kp.data_o !== e.data) begin
          failures++; $display("FAIL pulse_data: got %h expected %h", kp.data_o, e.data);
        end
        assertions++;
        if (kp.key_held_o !== 1'b1) begin
          failures++; $display("FAIL pulse_held: got %b expected 1", kp.key_held_o);
        end
      end
    end
    prev_valid = rst_ni && kp.key_valid_o;
  end

  task automatic align_scan();
    int n = 0;
    while (n < 40 && kp.col_o !== 4'b0111) begin @(negedge clk); n++; end
    while (n < 40 && kp.col_o === 4'b0111) begin @(negedge clk); n++; end
    if (n >= 40 || kp.col_o !== 4'b1110) begin
      assertions++; failures++;
      $display("FAIL align_scan: col_o=%b after %0d cycles, expected 1110", kp.col_o, n);
    end
  endtask

  task automatic hold(input logic [15:0] mask, input int scans);
    pressed = mask;
    repeat (scans * SCAN) @(negedge clk);
  endtask

  task automatic expect_accept(input logic [3:0] k);
    exp_data = {exp_data[DW-5:0], k};
    exp_q.push_back('{key: k, data: exp_data});
  endtask

  task automatic press_key(input int bit_idx, input logic [3:0] k);
    int t0;
    expect_accept(k);
    align_scan();
    t0 = cyc;
    hold(16'(1) << bit_idx, 4);
    hold('0, 4);
    assertions++;
    if (last_pulse_cyc != t0 + 48) begin
      failures++; $display("FAIL accept_latency_%h: pulse at %0d expected %0d", k, last_pulse_cyc, t0 + 48);
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_col;
    kp.clear_i = 1'b0;
    rst_ni = 1'b0;
    repeat (3) @(negedge clk);
    assertions++;
    if (kp.col_o !== 4'b1110 || kp.key_o !== 4'h0 || kp.key_valid_o !== 1'b0 ||
        kp.key_held_o !== 1'b0 || kp.data_o !== '0) begin
      failures++;
      $display("FAIL reset_values: col=%b key=%h valid=%b held=%b data=%h expected 1110/0/0/0/0",
               kp.col_o, kp.key_o, kp.key_valid_o, kp.key_held_o, kp.data_o);
    end
    rst_ni = 1'b1;
    for (int k = 0; k < 24; k++) begin
      exp_col = 4'b1111;
      exp_col[(k / 4) % 4] = 1'b0;
      assertions++;
      if (kp.col_o !== exp_col) begin
        failures++; $display("FAIL col_scan_%0d: got %b expected %b", k, kp.col_o, exp_col);
      end
      @(negedge clk);
    end
    repeat (3 * SCAN) @(negedge clk);
    assertions++;
    if (pulse_count != 0) begin
      failures++; $display("FAIL idle_no_pulse: %0d pulses expected 0", pulse_count);
    end
  endtask

  task automatic test_clean_press();
    int t0, p0;
    p0 = pulse_count;
    expect_accept(4'h6);
    align_scan();
    t0 = cyc;
    pressed = 16'(1) << 6;
    repeat (47) @(negedge clk);
    assertions++;
    if (kp.key_valid_o !== 1'b0 || kp.key_held_o !== 1'b0) begin
      failures++; $display("FAIL early_accept: valid=%b held=%b expected 0/0", kp.key_valid_o, kp.key_held_o);
    end
    @(negedge clk);
    assertions++;
    if (kp.key_valid_o !== 1'b1) begin
      failures++; $display("FAIL accept_after_3_scans: valid=%b expected 1", kp.key_valid_o);
    end
    repeat (10 * SCAN - 48) @(negedge clk);
    pressed = '0;
    repeat (47) @(negedge clk);
    assertions++;
    if (kp.key_held_o !== 1'b1) begin
      failures++; $display("FAIL held_before_release: got %b expected 1", kp.key_held_o);
    end
    @(negedge clk);
    assertions++;
    if (kp.key_held_o !== 1'b0) begin
      failures++; $display("FAIL held_drop_3_scans: got %b expected 0", kp.key_held_o);
    end
    repeat (SCAN) @(negedge clk);
    assertions++;
    if (pulse_count - p0 != 1 || last_pulse_cyc != t0 + 48) begin
      failures++;
      $display("FAIL clean_press_count: pulses=%0d at %0d expected 1 at %0d", pulse_count - p0, last_pulse_cyc, t0 + 48);
    end
    assertions++;
    if (kp.key_o !== 4'h6 || kp.data_o !== 32'h0000_0006) begin
      failures++; $display("FAIL clean_press_out: key=%h data=%h expected 6/00000006", kp.key_o, kp.data_o);
    end
  endtask

  task automatic test_bounce();
    int p0;
    p0 = pulse_count;
    align_scan();
    hold(16'h0001, 1);
    hold('0, 1);
    hold(16'h0001, 1);
    hold('0, 4);
    assertions++;
    if (pulse_count != p0 || kp.key_held_o !== 1'b0 || kp.data_o !== exp_data) begin
      failures++;
      $display("FAIL bounce: pulses=%0d held=%b data=%h expected 0/0/%h", pulse_count - p0, kp.key_held_o, kp.data_o, exp_data);
    end
  endtask

  task automatic test_entry_shift();
    int p0;
    p0 = pulse_count;
    for (int k = 1; k <= 9; k++) press_key(((k - 1) / 3) * 4 + (k - 1) % 3, 4'(k));
    assertions++;
    if (pulse_count - p0 != 9 || kp.data_o !== 32'h2345_6789) begin
      failures++; $display("FAIL entry_shift: pulses=%0d data=%h expected 9/23456789", pulse_count - p0, kp.data_o);
    end
  endtask

  task automatic test_multi_key();
    int p0;
    p0 = pulse_count;
    align_scan();
    hold(16'h0003, 4);
    hold('0, 4);
    assertions++;
    if (pulse_count != p0 || kp.key_held_o !== 1'b0) begin
      failures++; $display("FAIL multi_from_idle: pulses=%0d held=%b expected 0/0", pulse_count - p0, kp.key_held_o);
    end
    expect_accept(4'h5);
    align_scan();
    hold(16'(1) << 5, 4);
    hold((16'(1) << 5) | (16'(1) << 9), 3);
    assertions++;
    if (pulse_count - p0 != 1 || kp.key_o !== 4'h5 || kp.key_held_o !== 1'b1) begin
      failures++;
      $display("FAIL multi_while_held: pulses=%0d key=%h held=%b expected 1/5/1", pulse_count - p0, kp.key_o, kp.key_held_o);
    end
    hold('0, 4);
    assertions++;
    if (kp.key_held_o !== 1'b0 || kp.key_o !== 4'h5) begin
      failures++; $display("FAIL multi_release: held=%b key=%h expected 0/5", kp.key_held_o, kp.key_o);
    end
  endtask

  task automatic test_clear_and_reset();
    int t0;
    kp.clear_i = 1'b1;
    @(negedge clk);
    kp.clear_i = 1'b0;
    exp_data = '0;
    assertions++;
    if (kp.data_o !== '0 || kp.key_o !== 4'h5) begin
      failures++; $display("FAIL clear_alone: data=%h key=%h expected 0/5", kp.data_o, kp.key_o);
    end
    for (int k = 1; k <= 8; k++) press_key(((k - 1) / 3) * 4 + (k - 1) % 3, 4'(k));
    assertions++;
    if (kp.data_o !== 32'h1234_5678) begin
      failures++; $display("FAIL entry_before_clear: data=%h expected 12345678", kp.data_o);
    end
    exp_data = '0;
    expect_accept(4'hD);
    align_scan();
    pressed = 16'(1) << 15;
    repeat (47) @(negedge clk);
    kp.clear_i = 1'b1;
    @(negedge clk);
    kp.clear_i = 1'b0;
    repeat (SCAN) @(negedge clk);
    hold('0, 4);
    assertions++;
    if (kp.data_o !== 32'h0000_000D || kp.key_o !== 4'hD) begin
      failures++; $display("FAIL clear_with_accept: data=%h key=%h expected 0000000D/D", kp.data_o, kp.key_o);
    end
    align_scan();
    pressed = 16'(1) << 3;
    repeat (2 * SCAN) @(negedge clk);
    rst_ni = 1'b0;
    #1;
    assertions++;
    if (kp.col_o !== 4'b1110 || kp.key_o !== 4'h0 || kp.key_valid_o !== 1'b0 ||
        kp.key_held_o !== 1'b0 || kp.data_o !== '0) begin
      failures++;
      $display("FAIL reset_mid_debounce: col=%b key=%h valid=%b held=%b data=%h expected 1110/0/0/0/0",
               kp.col_o, kp.key_o, kp.key_valid_o, kp.key_held_o, kp.data_o);
    end
    repeat (2) @(negedge clk);
    exp_data = '0;
    expect_accept(4'hA);
    rst_ni = 1'b1;
    t0 = cyc;
    repeat (47) @(negedge clk);
    assertions++;
    if (kp.key_valid_o !== 1'b0) begin
      failures++; $display("FAIL reset_redebounce_early: valid=%b expected 0", kp.key_valid_o);
    end
    @(negedge clk);
    assertions++;
    if (kp.key_valid_o !== 1'b1 || kp.key_o !== 4'hA) begin
      failures++; $display("FAIL reset_redebounce: valid=%b key=%h expected 1/A", kp.key_valid_o, kp.key_o);
    end
    repeat (SCAN) @(negedge clk);
    hold('0, 4);
    assertions++;
    if (last_pulse_cyc != t0 + 48) begin
      failures++; $display("FAIL reset_redebounce_time: pulse at %0d expected %0d", last_pulse_cyc, t0 + 48);
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_entry_shift();
    test_multi_key();
    test_clear_and_reset();
    assertions++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL scoreboard_drain: %0d expected accepts never seen", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end
endmodule
